// File: rtl/activation_lut_pipe.sv
// activation_lut_pipe: three-stage activation unit (sigmoid / tanh / ReLU /
// identity). Sigmoid and tanh read a runtime-writable sigmoid LUT covering
// [-8, 8); tanh is formed as 2*sigmoid(2x) - 1 with saturation.
// All stages advance together on adv = out_ready | ~out_valid.
// Build option: define ACTIVATION_INTERP_EN to linearly interpolate between
// neighbouring LUT entries. Without it the lookup uses the floor entry and no
// multiplier is built.
module activation_lut_pipe #(
    parameter int WIDTH         = 32,
    parameter int FRAC_BITS     = 16,
    parameter int LUT_ADDR_BITS = 8,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [1:0]               in_mode,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_WIDTH-1:0]     out_tag,
    input  logic                     lut_we,
    input  logic [LUT_ADDR_BITS-1:0] lut_addr,
    input  logic [WIDTH-1:0]         lut_wdata
);

    // Operand bits below the LUT step; these form the interpolation fraction.
    localparam int SH    = FRAC_BITS + 4 - LUT_ADDR_BITS;
    localparam int FW    = (SH > 0) ? SH : 1;
    localparam int DEPTH = 1 << LUT_ADDR_BITS;
    localparam int OW    = WIDTH + 1;
    localparam int TW    = WIDTH + 3;

    localparam logic [1:0] M_SIGMOID  = 2'd0;
    localparam logic [1:0] M_TANH     = 2'd1;
    localparam logic [1:0] M_RELU     = 2'd2;
    localparam logic [1:0] M_IDENTITY = 2'd3;

    localparam logic signed [OW-1:0] C_POS8 = OW'(8) << FRAC_BITS;
    localparam logic signed [OW-1:0] C_NEG8 = -C_POS8;
    localparam logic [LUT_ADDR_BITS-1:0] C_IDX_OFS = LUT_ADDR_BITS'(1) << (LUT_ADDR_BITS - 1);
    localparam logic [LUT_ADDR_BITS-1:0] C_IDX_TOP = '1;

    localparam logic signed [TW-1:0] C_T_ONE = TW'(1) << FRAC_BITS;
    localparam logic signed [TW-1:0] C_T_MAX = C_T_ONE - TW'(1);
    localparam logic signed [TW-1:0] C_T_MIN = -C_T_ONE;

    logic [WIDTH-1:0] r_lut [DEPTH];

    logic                     w_adv;

    logic signed [OW-1:0]     w_op;
    logic [LUT_ADDR_BITS-1:0] w_s0_idx;

    logic                     r_s0_valid;
    logic [1:0]               r_s0_mode;
    logic [TAG_WIDTH-1:0]     r_s0_tag;
    logic [WIDTH-1:0]         r_s0_x;
    logic [LUT_ADDR_BITS-1:0] r_s0_idx;

    logic                     r_s1_valid;
    logic [1:0]               r_s1_mode;
    logic [TAG_WIDTH-1:0]     r_s1_tag;
    logic [WIDTH-1:0]         r_s1_x;
    logic [WIDTH-1:0]         r_s1_l0;

    logic [WIDTH-1:0]         w_ly;
    logic signed [TW-1:0]     w_tanh_full;
    logic [WIDTH-1:0]         w_tanh;
    logic [WIDTH-1:0]         w_y;

    logic                     r_out_valid;
    logic [WIDTH-1:0]         r_out_data;
    logic [TAG_WIDTH-1:0]     r_out_tag;

    assign w_adv     = out_ready | ~r_out_valid;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

    // tanh needs sigmoid(2x); the doubled value gets one extra bit so it never wraps.
    assign w_op = (in_mode == M_TANH) ? {in_data, 1'b0} : {in_data[WIDTH-1], in_data};

`ifdef ACTIVATION_INTERP_EN
    logic [FW-1:0]            w_s0_frac;
    logic [FW-1:0]            r_s0_frac;
    logic [FW-1:0]            r_s1_frac;
    logic [WIDTH-1:0]         r_s1_l1;
    logic [LUT_ADDR_BITS-1:0] w_idx_nxt;
    logic signed [WIDTH:0]       w_diff;
    logic signed [2*WIDTH-1:0]   w_prod;
    logic signed [2*WIDTH-1:0]   w_corr;
`endif

    // S0: map the operand onto a LUT index, clamping outside [-8, 8).
    always_comb begin
        w_s0_idx = w_op[SH + LUT_ADDR_BITS - 1 -: LUT_ADDR_BITS] + C_IDX_OFS;
`ifdef ACTIVATION_INTERP_EN
        w_s0_frac = (SH > 0) ? w_op[FW-1:0] : '0;
`endif
        if (w_op < C_NEG8) begin
            w_s0_idx = '0;
`ifdef ACTIVATION_INTERP_EN
            w_s0_frac = '0;
`endif
        end else if (w_op >= C_POS8) begin
            w_s0_idx = C_IDX_TOP;
`ifdef ACTIVATION_INTERP_EN
            w_s0_frac = '0;
`endif
        end
    end

    // LUT write port; writes during reset are dropped, contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && lut_we) begin
            r_lut[lut_addr] <= lut_wdata;
        end
    end

    // Stage payloads (no reset needed): S0 capture and the registered LUT read in S1.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s0_mode <= in_mode;
            r_s0_tag  <= in_tag;
            r_s0_x    <= in_data;
            r_s0_idx  <= w_s0_idx;
            r_s1_mode <= r_s0_mode;
            r_s1_tag  <= r_s0_tag;
            r_s1_x    <= r_s0_x;
            r_s1_l0   <= r_lut[r_s0_idx];
`ifdef ACTIVATION_INTERP_EN
            r_s0_frac <= w_s0_frac;
            r_s1_frac <= r_s0_frac;
            r_s1_l1   <= r_lut[w_idx_nxt];
`endif
        end
    end

`ifdef ACTIVATION_INTERP_EN
    // At the top entry there is no upper neighbour, so reuse the entry itself.
    assign w_idx_nxt = (r_s0_idx == C_IDX_TOP) ? r_s0_idx : r_s0_idx + LUT_ADDR_BITS'(1);
    assign w_diff    = $signed({1'b0, r_s1_l1}) - $signed({1'b0, r_s1_l0});
    assign w_prod    = $signed({{(WIDTH-1){w_diff[WIDTH]}}, w_diff})
                     * $signed({{(2*WIDTH-FW){1'b0}}, r_s1_frac});
    assign w_corr    = w_prod >>> SH;
    assign w_ly      = r_s1_l0 + w_corr[WIDTH-1:0];
`else
    assign w_ly      = r_s1_l0;
`endif

    // tanh = 2*sigmoid - 1, evaluated wide enough that any LUT word is representable.
    assign w_tanh_full = $signed({2'b00, w_ly, 1'b0}) - C_T_ONE;

    // Saturate tanh to [-1, 1 - lsb].
    always_comb begin
        w_tanh = w_tanh_full[WIDTH-1:0];
        if (w_tanh_full > C_T_MAX) begin
            w_tanh = C_T_MAX[WIDTH-1:0];
        end else if (w_tanh_full < C_T_MIN) begin
            w_tanh = C_T_MIN[WIDTH-1:0];
        end
    end

    // S2: select the result for the sample's mode.
    always_comb begin
        w_y = r_s1_x;
        case (r_s1_mode)
            M_SIGMOID:  w_y = w_ly;
            M_TANH:     w_y = w_tanh;
            M_RELU:     w_y = (!r_s1_x[WIDTH-1] && (r_s1_x != '0)) ? r_s1_x : '0;
            M_IDENTITY: w_y = r_s1_x;
            default:    w_y = r_s1_x;
        endcase
    end

    // Valid chain and output register; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid  <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else if (w_adv) begin
            r_s0_valid  <= in_valid;
            r_s1_valid  <= r_s0_valid;
            r_out_valid <= r_s1_valid;
            r_out_data  <= w_y;
            r_out_tag   <= r_s1_tag;
        end
    end

endmodule
